cp0_int_src: RTL and testbench

- Interrupt-source stage directly upstream of CP0.
- Synchronises the six asynchronous hardware interrupt lines and implements the Count/Compare timer with its timer interrupt.
- Merges both into the hardware IP vector feeding Cause[15:10].
- Produces a registered interrupt request, qualified by Status IE/EXL/IM, that CP0's interrupt-entry branch consumes.

---
 rtl/cp0_int_src_if.sv | 30 +++
 rtl/cp0_int_src.sv | 125 ++++++++++++
 tb/tb_cp0_int_src.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/cp0_int_src_if.sv
// Signal bundle between CP0 and its interrupt-source stage.
// master = CP0 side (drives lines, writes, Status/Cause); slave = cp0_int_src.
interface cp0_int_src_if;
  logic [5:0]  ext_int;
  logic        cp0_we;
  logic [4:0]  cp0_num;
  logic [2:0]  cp0_sel;
  logic [31:0] cp0_wdata;
  logic        status_ie;
  logic        status_exl;
  logic [7:0]  status_im;
  logic [1:0]  cause_ip_sw;
  logic [31:0] count;
  logic [31:0] compare;
  logic        ti;
  logic [5:0]  ip_hw;
  logic        int_req;

  modport master (
    output ext_int, cp0_we, cp0_num, cp0_sel, cp0_wdata,
           status_ie, status_exl, status_im, cause_ip_sw,
    input  count, compare, ti, ip_hw, int_req
  );

  modport slave (
    input  ext_int, cp0_we, cp0_num, cp0_sel, cp0_wdata,
           status_ie, status_exl, status_im, cause_ip_sw,
    output count, compare, ti, ip_hw, int_req
  );
endinterface

// File: rtl/cp0_int_src.sv
// Interrupt-source stage ahead of CP0: ext_int synchronisers, Count/Compare timer, IP merge
// and registered int_req. Define CP0_TIMER_INT_EN to enable the Compare match and ti.
module cp0_int_src #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned COUNT_DIV   = 2,
  parameter int unsigned TI_LINE     = 5
) (
  input logic          clk,
  input logic          resetn,
  cp0_int_src_if.slave bus
);

  localparam logic [3:0] DivMax = 4'(COUNT_DIV - 1);

  logic [3:0]  div_q, div_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic [5:0]  sync_q [SYNC_STAGES];
  logic        int_req_q, int_req_d;
  logic        tick;
  logic        count_wr;
  logic        compare_wr;
  logic        ti_w;
  logic [5:0]  ip_hw;

  assign count_wr   = bus.cp0_we && (bus.cp0_num == 5'd9)  && (bus.cp0_sel == 3'd0);
  assign compare_wr = bus.cp0_we && (bus.cp0_num == 5'd11) && (bus.cp0_sel == 3'd0);
  assign tick       = (div_q == DivMax);

  // A Count write restarts the prescaler and overrides a same-cycle increment.
  always_comb begin
    div_d   = tick ? 4'd0 : 4'(div_q + 4'd1);
    count_d = count_q;
    if (count_wr) begin
      count_d = bus.cp0_wdata;
      div_d   = 4'd0;
    end else if (tick) begin
      count_d = count_q + 32'd1;
    end
  end

  always_comb begin
    compare_d = compare_q;
    if (compare_wr) begin
      compare_d = bus.cp0_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      div_q     <= 4'd0;
      count_q   <= 32'd0;
      compare_q <= 32'd0;
    end else begin
      div_q     <= div_d;
      count_q   <= count_d;
      compare_q <= compare_d;
    end
  end

`ifdef CP0_TIMER_INT_EN
  logic ti_q, ti_d;
  logic match;

  // Match only on a real increment, so writing Count==Compare never fires the timer.
  assign match = tick && !count_wr && ((count_q + 32'd1) == compare_q);

  always_comb begin
    ti_d = ti_q | match;
    if (compare_wr) begin
      ti_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ti_q <= 1'b0;
    end else begin
      ti_q <= ti_d;
    end
  end

  assign ti_w = ti_q;
`else
  assign ti_w = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= 6'd0;
      end
    end else begin
      sync_q[0] <= bus.ext_int;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  always_comb begin
    ip_hw          = sync_q[SYNC_STAGES-1];
    ip_hw[TI_LINE] = sync_q[SYNC_STAGES-1][TI_LINE] | ti_w;
  end

  always_comb begin
    int_req_d = bus.status_ie && !bus.status_exl &&
                (|(bus.status_im & {ip_hw, bus.cause_ip_sw}));
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      int_req_q <= 1'b0;
    end else begin
      int_req_q <= int_req_d;
    end
  end

  assign bus.count   = count_q;
  assign bus.compare = compare_q;
  assign bus.ti      = ti_w;
  assign bus.ip_hw   = ip_hw;
  assign bus.int_req = int_req_q;

endmodule

// File: tb/tb_cp0_int_src.sv
// Randomised bench for cp0_int_src against a cycle-level behavioural model.
module tb_cp0_int_src;

  localparam int unsigned SyncStages = 2;
  localparam int unsigned CountDiv   = 2;
  localparam int unsigned TiLine     = 5;
`ifdef CP0_TIMER_INT_EN
  localparam bit TimerEn = 1'b1;
`else
  localparam bit TimerEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  cp0_int_src_if bus ();

  cp0_int_src #(
    .SYNC_STAGES(SyncStages),
    .COUNT_DIV  (CountDiv),
    .TI_LINE    (TiLine)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference state
  logic [31:0] m_count, m_compare;
  logic        m_ti, m_int_req;
  int          m_epoch;  // clocks since reset or last Count write
  logic [5:0]  m_hist [SyncStages];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] model_ip();
    logic [5:0] ip;
    ip = m_hist[SyncStages-1];
    if (m_ti) ip[TiLine] = 1'b1;
    return ip;
  endfunction

  task automatic model_step();
    logic cw, pw, tk, rq;
    if (!resetn) begin
      m_count = 0; m_compare = 0; m_ti = 0; m_int_req = 0; m_epoch = 0;
      for (int i = 0; i < int'(SyncStages); i++) m_hist[i] = 0;
    end else begin
      rq = bus.status_ie && !bus.status_exl && (|(bus.status_im & {model_ip(), bus.cause_ip_sw}));
      cw = bus.cp0_we && bus.cp0_num == 9  && bus.cp0_sel == 0;
      pw = bus.cp0_we && bus.cp0_num == 11 && bus.cp0_sel == 0;
      tk = (m_epoch % CountDiv) == (CountDiv - 1);
      if (TimerEn && tk && !cw && (m_count + 32'd1 == m_compare)) m_ti = 1;
      if (pw) begin
        m_ti = 0;
        m_compare = bus.cp0_wdata;
      end
      if (cw) begin
        m_count = bus.cp0_wdata;
        m_epoch = 0;
      end else begin
        if (tk) m_count = m_count + 32'd1;
        m_epoch++;
      end
      for (int i = int'(SyncStages) - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = bus.ext_int;
      m_int_req = rq;
    end
  endtask

  task automatic compare_all();
    check_eq("count",   bus.count,   m_count);
    check_eq("compare", bus.compare, m_compare);
    check_eq("ti",      32'(bus.ti),      32'(m_ti));
    check_eq("ip_hw",   32'(bus.ip_hw),   32'(model_ip()));
    check_eq("int_req", 32'(bus.int_req), 32'(m_int_req));
  endtask

  // Inputs are changed only just after a falling edge, after the outputs are compared.
  task automatic clk_cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    bus.cp0_we = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) clk_cycle();
  endtask

  task automatic cp0_write(input logic [4:0] num, input logic [31:0] data);
    bus.cp0_we    = 1'b1;
    bus.cp0_num   = num;
    bus.cp0_sel   = 3'd0;
    bus.cp0_wdata = data;
    clk_cycle();
  endtask

  initial begin
    bus.ext_int = 0; bus.cp0_we = 0; bus.cp0_num = 0; bus.cp0_sel = 0; bus.cp0_wdata = 0;
    bus.status_ie = 0; bus.status_exl = 0; bus.status_im = 0; bus.cause_ip_sw = 0;
    m_epoch = 0;
    @(negedge clk);
    resetn = 1'b0;
    idle(3);
    check_eq("rst_count", bus.count, 32'd0);
    check_eq("rst_ip_hw", 32'(bus.ip_hw), 32'd0);
    check_eq("rst_int_req", 32'(bus.int_req), 32'd0);

    // Free-running Count from reset
    resetn = 1'b1;
    idle(20);
    check_eq("t1_count", bus.count, 32'd10);
    check_eq("t1_ti", 32'(bus.ti), 32'd0);

    // Compare match with int_req via IM[7]
    bus.status_ie = 1'b1;
    bus.status_im = 8'h80;
    cp0_write(5'd11, 32'h10);
    cp0_write(5'd9, 32'h0C);
    idle(10);
    cp0_write(5'd11, 32'h20);
    check_eq("t2_ti_clear", 32'(bus.ti), 32'd0);
    idle(2);

    // Match across the 32-bit wrap
    cp0_write(5'd9, 32'hFFFF_FFFE);
    cp0_write(5'd11, 32'h0);
    idle(8);

    // ext_int latency and EXL masking
    bus.status_im = 8'h10;
    bus.ext_int   = 6'b000100;
    clk_cycle();
    check_eq("t4_ip2_early", 32'(bus.ip_hw[2]), 32'd0);
    clk_cycle();
    check_eq("t4_ip2", 32'(bus.ip_hw[2]), 32'd1);
    clk_cycle();
    check_eq("t4_req", 32'(bus.int_req), 32'd1);
    bus.status_exl = 1'b1;
    clk_cycle();
    check_eq("t4_req_exl", 32'(bus.int_req), 32'd0);
    bus.status_exl = 1'b0;
    bus.ext_int    = 6'b0;
    idle(4);

    // Count write coinciding with a tick
    cp0_write(5'd9, 32'h100);
    clk_cycle();
    cp0_write(5'd9, 32'h5);
    check_eq("t5_count_wr", bus.count, 32'h5);
    clk_cycle();
    check_eq("t5_hold", bus.count, 32'h5);
    clk_cycle();
    check_eq("t5_incr", bus.count, 32'h6);

    // Compare write on the matching tick: clear wins
    cp0_write(5'd11, 32'h1FF);
    cp0_write(5'd9, 32'h1FD);
    idle(3);
    cp0_write(5'd11, 32'h300);
    check_eq("t5_cmp_clear", 32'(bus.ti), 32'd0);
    check_eq("t5_cmp_rd", bus.compare, 32'h300);

    // Other register numbers/selects are ignored
    cp0_write(5'd12, 32'hDEAD_BEEF);
    bus.cp0_we = 1'b1; bus.cp0_num = 5'd9; bus.cp0_sel = 3'd1; bus.cp0_wdata = 32'h1234;
    clk_cycle();
    check_eq("ign_compare", bus.compare, 32'h300);

    // Randomised traffic
    for (int n = 0; n < 600; n++) begin
      resetn = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 7) == 0) bus.ext_int = 6'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        bus.status_ie   = 1'($urandom);
        bus.status_exl  = ($urandom_range(0, 3) == 0);
        bus.status_im   = 8'($urandom);
        bus.cause_ip_sw = 2'($urandom);
      end
      if ($urandom_range(0, 3) == 0) begin
        bus.cp0_we = 1'b1;
        case ($urandom_range(0, 4))
          0, 1:    bus.cp0_num = 5'd11;
          2:       bus.cp0_num = 5'd9;
          default: bus.cp0_num = 5'($urandom);
        endcase
        bus.cp0_sel   = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'd0;
        bus.cp0_wdata = ($urandom_range(0, 3) == 0) ? $urandom
                                                    : m_count + 32'($urandom_range(0, 6));
      end
      clk_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
